// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: turns arrow-key and 'S' make codes into a held
// one-hot direction, a direction-update strobe and a start strobe.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       dir_pulse,
  output logic       start_key,
  output logic       rx_error
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  logic [1:0]   clk_sync;
  logic [1:0]   dat_sync;
  logic         clk_s;
  logic         dat_s;

  logic [FW-1:0] filt_cnt;
  logic          filt_lvl;
  logic          filt_prev;
  logic          fall_c;

  frame_state_t  fstate;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_bad;

  logic          ext;
  logic          brk;
  logic [8:0]    held;
  logic [8:0]    key_c;

  assign clk_s  = clk_sync[1];
  assign dat_s  = dat_sync[1];
  assign fall_c = filt_prev & ~filt_lvl;
  assign key_c  = {ext, rx_byte};

  // Two-flop synchronisers on both PS/2 lines; idle level is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Glitch filter: accept a new ps2_clk level after FILTER_LEN agreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt  <= '0;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_lvl;
      if (clk_s == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_lvl <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; with timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      fstate     <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_bad  <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      rx_error   <= 1'b0;

      if (fstate == IDLE || fall_c) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (fstate != IDLE && !fall_c && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard went quiet mid-frame: drop the partial byte.
        fstate   <= IDLE;
        shift    <= '0;
        bit_cnt  <= '0;
        tmo_cnt  <= '0;
        rx_error <= 1'b1;
      end else if (fall_c) begin
        case (fstate)
          IDLE: begin
            if (!dat_s) begin
              fstate  <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              fstate <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= dat_s;
            fstate     <= STOP;
          end
          STOP: begin
            if (dat_s && (^{shift, parity_bit})) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift;
            end else begin
              rx_error  <= 1'b1;
              frame_bad <= 1'b1;
            end
            fstate <= IDLE;
          end
          default: fstate <= IDLE;
        endcase
      end
    end
  end

  // Scan-code decoder: E0/F0 prefixes, typematic suppression, key mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      held      <= '0;
      direction <= 4'b0000;
      dir_pulse <= 1'b0;
      start_key <= 1'b0;
    end else begin
      dir_pulse <= 1'b0;
      start_key <= 1'b0;
      if (frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            if (key_c == held) begin
              held <= '0;
            end
          end else if (key_c != held) begin
            held <= key_c;
            case (key_c)
              9'h175: begin direction <= 4'b1000; dir_pulse <= 1'b1; end
              9'h172: begin direction <= 4'b0100; dir_pulse <= 1'b1; end
              9'h16B: begin direction <= 4'b0010; dir_pulse <= 1'b1; end
              9'h174: begin direction <= 4'b0001; dir_pulse <= 1'b1; end
              9'h01B: start_key <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames bit by bit,
// predicts strobes with a scan-code model and checks the DUT every cycle.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] direction;
  logic       dir_pulse;
  logic       start_key;
  logic       rx_error;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .direction (direction),
    .dir_pulse (dir_pulse),
    .start_key (start_key),
    .rx_error  (rx_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 1 = dir_pulse, 2 = start_key, 3 = rx_error
  typedef struct {
    int         kind;
    logic [3:0] dir;
    int         t_lo;
    int         t_hi;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         dir_seen = 0;
  int         start_seen = 0;
  int         err_seen = 0;
  logic [3:0] shown_dir = 4'b0000;

  // model state
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [8:0] m_held = 9'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] d, input int t, input int lo, input int hi);
    q.push_back('{kind, d, t + lo, t + hi});
  endtask

  // Behavioural scan-code model; t is the cycle of the raw stop-bit falling edge.
  task automatic model_rx(input logic [7:0] b, input bit ok, input int t);
    logic [8:0] key;
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      push(3, 4'b0000, t, FILT, FILT + 6);
      return;
    end
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1'b1;
      return;
    end
    key = {m_ext, b};
    m_ext = 1'b0;
    if (m_brk) begin
      m_brk = 1'b0;
      if (key == m_held) m_held = 9'h000;
      return;
    end
    if (key == m_held) return;
    m_held = key;
    if (key == 9'h175) push(1, 4'b1000, t, FILT, FILT + 6);
    else if (key == 9'h172) push(1, 4'b0100, t, FILT, FILT + 6);
    else if (key == 9'h16B) push(1, 4'b0010, t, FILT, FILT + 6);
    else if (key == 9'h174) push(1, 4'b0001, t, FILT, FILT + 6);
    else if (key == 9'h01B) push(2, 4'b0000, t, FILT, FILT + 6);
  endtask

  task automatic model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_held = 9'h000;
    q.delete();
    shown_dir = 4'b0000;
  endtask

  // Compare process: every strobe must match the next predicted event.
  exp_t e;
  int   kind_act;
  int   nstrobe;
  always @(negedge clock) begin
    if (!reset) begin
      nstrobe = int'(dir_pulse) + int'(start_key) + int'(rx_error);
      if (nstrobe > 0) begin
        if (dir_pulse) dir_seen++;
        if (start_key) start_seen++;
        if (rx_error) err_seen++;
        check("strobe_exclusive", 32'(nstrobe), 32'd1);
        kind_act = dir_pulse ? 1 : (start_key ? 2 : 3);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind_act, cyc);
        end else begin
          e = q.pop_front();
          check("strobe_kind", 32'(kind_act), 32'(e.kind));
          checks++;
          if (cyc < e.t_lo || cyc > e.t_hi) begin
            errors++;
            $display("FAIL strobe_latency: got cycle %0d expected %0d..%0d", cyc, e.t_lo, e.t_hi);
          end
          if (e.kind == 1) shown_dir = e.dir;
        end
      end
      check("direction", 32'(direction), 32'(shown_dir));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, output int t);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    t = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // err: 0 = good, 1 = bad parity, 2 = bad stop bit
  task automatic send_frame(input logic [7:0] b, input int err);
    int   t;
    logic par;
    logic stp;
    par = ~(^b) ^ (err == 1);
    stp = (err == 2) ? 1'b0 : 1'b1;
    send_bit(1'b0, t);
    for (int i = 0; i < 8; i++) send_bit(b[i], t);
    send_bit(par, t);
    ps2_dat = stp;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    model_rx(b, err == 0, cyc);
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, output int t);
    send_bit(1'b0, t);
    for (int i = 0; i < nbits; i++) send_bit(b[i], t);
    ps2_dat = 1'b1;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) wait_cyc(1);
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int d0, s0, r0, t, sel, errk;
  logic [7:0] pool [8];

  initial begin
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(5);
    check("reset_direction", 32'(direction), 32'd0);
    check("reset_strobes", {29'd0, dir_pulse, start_key, rx_error}, 32'd0);
    reset = 1'b0;

    // Idle lines well past the timeout: nothing may happen.
    wait_cyc(2 * TMO + 1000);
    check("idle_err", 32'(err_seen), 32'd0);
    check("idle_dir", 32'(direction), 32'd0);

    // E0,74 -> right
    d0 = dir_seen;
    send_frame(8'hE0, 0);
    send_frame(8'h74, 0);
    drain(100);
    check("right_pulses", 32'(dir_seen - d0), 32'd1);
    check("right_dir", 32'(direction), 32'h1);

    // up, repeat, release, up again -> two pulses
    d0 = dir_seen;
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    drain(100);
    check("up_pulses", 32'(dir_seen - d0), 32'd2);
    check("up_dir", 32'(direction), 32'h8);

    // S make/break, then 6B without E0
    d0 = dir_seen; s0 = start_seen;
    send_frame(8'h1B, 0);
    send_frame(8'hF0, 0); send_frame(8'h1B, 0);
    send_frame(8'h6B, 0);
    drain(100);
    check("start_pulses", 32'(start_seen - s0), 32'd1);
    check("start_no_dir", 32'(dir_seen - d0), 32'd0);
    check("start_dir_held", 32'(direction), 32'h8);

    // Bad parity, then valid down
    d0 = dir_seen; r0 = err_seen;
    send_frame(8'h74, 1);
    drain(100);
    check("parity_err", 32'(err_seen - r0), 32'd1);
    check("parity_no_dir", 32'(dir_seen - d0), 32'd0);
    send_frame(8'hE0, 0); send_frame(8'h72, 0);
    drain(100);
    check("down_dir", 32'(direction), 32'h4);

    // Timeout after 5 data bits, then left
    r0 = err_seen;
    send_partial(8'h6B, 5, t);
    push(3, 4'b0000, t, TMO, TMO + FILT + 10);
    drain(TMO + 200);
    check("timeout_err", 32'(err_seen - r0), 32'd1);
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    drain(100);
    check("left_dir", 32'(direction), 32'h2);

    // Reset mid-frame, then left again decodes normally
    send_partial(8'h72, 3, t);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset_dir", 32'(direction), 32'd0);
    check("midreset_strobes", {29'd0, dir_pulse, start_key, rx_error}, 32'd0);
    model_reset();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4 * HALF);
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    drain(100);
    check("after_reset_dir", 32'(direction), 32'h2);

    // Randomised traffic from a pool of interesting bytes plus random ones
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75; pool[3] = 8'h72;
    pool[4] = 8'h6B; pool[5] = 8'h74; pool[6] = 8'h1B; pool[7] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 7) pool[7] = 8'($urandom);
      errk = int'($urandom_range(0, 19));
      send_frame(pool[sel], (errk == 0) ? 1 : ((errk == 1) ? 2 : 0));
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
